// File: rtl/axil_slave_pkg.sv
// Shared definitions for the AXI4-Lite crypto responder: response codes, register
// indices, channel state encodings and access-legality helpers.
package axil_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned IDX_NONCE  = 0;
  localparam int unsigned IDX_AD     = 1;
  localparam int unsigned IDX_PT     = 2;
  localparam int unsigned IDX_CT     = 3;
  localparam int unsigned IDX_STATUS = 4;
  localparam int unsigned IDX_KEY    = 5;

  typedef enum logic [2:0] {
    W_IDLE,
    W_ADDR_WAIT,
    W_DATA_WAIT,
    W_CORE,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_CORE,
    R_RESP
  } rd_state_e;

  function automatic logic wr_legal(input int unsigned idx);
    return (idx == IDX_NONCE) || (idx == IDX_AD) || (idx == IDX_PT) || (idx == IDX_KEY);
  endfunction

  function automatic logic rd_legal(input int unsigned idx);
    return (idx == IDX_CT) || (idx == IDX_STATUS);
  endfunction

endpackage

// File: rtl/axil_wr_chan.sv
// AXI4-Lite write channel: AW/W capture, core write request with ack timeout, B response.
// Define AXIL_PROT_CHECK_EN to reject unprivileged KEY writes with SLVERR.
//   state       | meaning
//   W_IDLE      | both AW and W may be accepted
//   W_ADDR_WAIT | W captured, waiting for AW
//   W_DATA_WAIT | AW captured, waiting for W
//   W_CORE      | wr_valid_o held until wr_ready_i or timeout
//   W_RESP      | bvalid_o held until bready_i
module axil_wr_chan
  import axil_slave_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int ADDR_LSB    = 0,
  parameter int IDX_W       = 3,
  parameter int ACK_TIMEOUT = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic [2:0]          awprot_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic                bvalid_o,
  input  logic                bready_i,
  output logic [1:0]          bresp_o,
  output logic                wr_valid_o,
  output logic [IDX_W-1:0]    wr_sel_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic [DATA_W/8-1:0] wr_be_o,
  input  logic                wr_ready_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int TC     = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TC);

  wr_state_e          state_q, state_d;
  logic               awready_q, awready_d;
  logic               wready_q, wready_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               prot_q, prot_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [STRB_W-1:0]  be_q, be_d;
  logic [1:0]         bresp_q, bresp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               aw_hs, w_hs, have_aw, have_w, timeout;
  logic [IDX_W-1:0]   aw_idx, eff_idx;
  logic               eff_prot, eff_legal;
  logic               unused_w;

  assign aw_hs    = awvalid_i & awready_q;
  assign w_hs     = wvalid_i & wready_q;
  assign have_aw  = aw_hs | (state_q == W_DATA_WAIT);
  assign have_w   = w_hs | (state_q == W_ADDR_WAIT);
  assign aw_idx   = awaddr_i[ADDR_LSB +: IDX_W];
  // The final decision uses whichever half of the address phase is arriving now.
  assign eff_idx  = aw_hs ? aw_idx : sel_q;
  assign eff_prot = aw_hs ? awprot_i[0] : prot_q;
  assign timeout  = (ACK_TIMEOUT != 0) && (cnt_q == CNT_TC);

`ifdef AXIL_PROT_CHECK_EN
  assign eff_legal = wr_legal(32'(eff_idx)) && !((32'(eff_idx) == IDX_KEY) && !eff_prot);
  assign unused_w  = ^{awaddr_i, awprot_i[2:1]};
`else
  assign eff_legal = wr_legal(32'(eff_idx));
  assign unused_w  = ^{awaddr_i, awprot_i, eff_prot};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      sel_q     <= '0;
      prot_q    <= 1'b0;
      data_q    <= '0;
      be_q      <= '0;
      bresp_q   <= RESP_OKAY;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      sel_q     <= sel_d;
      prot_q    <= prot_d;
      data_q    <= data_d;
      be_q      <= be_d;
      bresp_q   <= bresp_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    prot_d  = prot_q;
    data_d  = data_q;
    be_d    = be_q;
    bresp_d = bresp_q;
    cnt_d   = cnt_q;

    if (aw_hs) begin
      sel_d  = aw_idx;
      prot_d = awprot_i[0];
    end
    if (w_hs) begin
      data_d = wdata_i;
      be_d   = be_i;
    end

    case (state_q)
      W_IDLE, W_ADDR_WAIT, W_DATA_WAIT: begin
        if (have_aw && have_w) begin
          if (eff_legal) begin
            state_d = W_CORE;
            cnt_d   = '0;
          end else begin
            state_d = W_RESP;
            bresp_d = RESP_SLVERR;
          end
        end else if (have_aw) begin
          state_d = W_DATA_WAIT;
        end else if (have_w) begin
          state_d = W_ADDR_WAIT;
        end
      end
      W_CORE: begin
        if (wr_ready_i) begin
          state_d = W_RESP;
          bresp_d = RESP_OKAY;
        end else if (timeout) begin
          state_d = W_RESP;
          bresp_d = RESP_SLVERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      W_RESP: begin
        if (bready_i) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase

    // Readies are registered from the next state so a finishing B never overlaps a new AW.
    awready_d = (state_d == W_IDLE) || (state_d == W_ADDR_WAIT);
    wready_d  = (state_d == W_IDLE) || (state_d == W_DATA_WAIT);
  end

  assign awready_o  = awready_q;
  assign wready_o   = wready_q;
  assign bvalid_o   = (state_q == W_RESP);
  assign bresp_o    = bresp_q;
  assign wr_valid_o = (state_q == W_CORE);
  assign wr_sel_o   = sel_q;
  assign wr_data_o  = data_q;
  assign wr_be_o    = be_q;

endmodule

// File: rtl/axil_crypto_slave.sv
// AXI4-Lite responder in front of a crypto core; write channel in axil_wr_chan, read FSM here.
// Define AXIL_PROT_CHECK_EN to reject unprivileged KEY writes with SLVERR.
//   state  | meaning
//   R_IDLE | arready_o high, waiting for AR
//   R_CORE | rd_req_o held until rd_ack_i or timeout
//   R_RESP | rvalid_o held until rready_i
module axil_crypto_slave
  import axil_slave_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int ADDR_LSB    = 0,
  parameter int IDX_W       = 3,
  parameter int ACK_TIMEOUT = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic [2:0]          awprot_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic                bvalid_o,
  input  logic                bready_i,
  output logic [1:0]          bresp_o,
  input  logic                arvalid_i,
  output logic                arready_o,
  input  logic [ADDR_W-1:0]   araddr_i,
  input  logic [2:0]          arprot_i,
  output logic                rvalid_o,
  input  logic                rready_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          rresp_o,
  output logic                wr_valid_o,
  output logic [IDX_W-1:0]    wr_sel_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic [DATA_W/8-1:0] wr_be_o,
  input  logic                wr_ready_i,
  output logic                rd_req_o,
  output logic [IDX_W-1:0]    rd_sel_o,
  input  logic                rd_ack_i,
  input  logic [DATA_W-1:0]   rd_data_i
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int TC    = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TC);

  axil_wr_chan #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .ADDR_LSB    (ADDR_LSB),
    .IDX_W       (IDX_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_wr_chan (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .awvalid_i  (awvalid_i),
    .awready_o  (awready_o),
    .awaddr_i   (awaddr_i),
    .awprot_i   (awprot_i),
    .wvalid_i   (wvalid_i),
    .wready_o   (wready_o),
    .wdata_i    (wdata_i),
    .be_i       (be_i),
    .bvalid_o   (bvalid_o),
    .bready_i   (bready_i),
    .bresp_o    (bresp_o),
    .wr_valid_o (wr_valid_o),
    .wr_sel_o   (wr_sel_o),
    .wr_data_o  (wr_data_o),
    .wr_be_o    (wr_be_o),
    .wr_ready_i (wr_ready_i)
  );

  rd_state_e         state_q, state_d;
  logic              arready_q, arready_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              ar_hs, timeout;
  logic [IDX_W-1:0]  ar_idx;
  logic              unused_r;

  assign ar_hs    = arvalid_i & arready_q;
  assign ar_idx   = araddr_i[ADDR_LSB +: IDX_W];
  assign timeout  = (ACK_TIMEOUT != 0) && (cnt_q == CNT_TC);
  assign unused_r = ^{araddr_i, arprot_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= R_IDLE;
      arready_q <= 1'b0;
      sel_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    cnt_d   = cnt_q;

    case (state_q)
      R_IDLE: begin
        if (ar_hs) begin
          sel_d = ar_idx;
          if (rd_legal(32'(ar_idx))) begin
            state_d = R_CORE;
            cnt_d   = '0;
          end else begin
            state_d = R_RESP;
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end
      end
      R_CORE: begin
        if (rd_ack_i) begin
          state_d = R_RESP;
          rdata_d = rd_data_i;
          rresp_d = RESP_OKAY;
        end else if (timeout) begin
          state_d = R_RESP;
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_RESP: begin
        if (rready_i) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase

    arready_d = (state_d == R_IDLE);
  end

  assign arready_o = arready_q;
  assign rd_req_o  = (state_q == R_CORE);
  assign rd_sel_o  = sel_q;
  assign rvalid_o  = (state_q == R_RESP);
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;

endmodule

// File: tb/tb_axil_crypto_slave.sv
// Directed and randomized checks of axil_crypto_slave against a transaction-level model.
module tb_axil_crypto_slave;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = 3;
  localparam int TO     = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              awvalid_i, awready_o;
  logic [ADDR_W-1:0] awaddr_i;
  logic [2:0]        awprot_i;
  logic              wvalid_i, wready_o;
  logic [DATA_W-1:0] wdata_i;
  logic [3:0]        be_i;
  logic              bvalid_o, bready_i;
  logic [1:0]        bresp_o;
  logic              arvalid_i, arready_o;
  logic [ADDR_W-1:0] araddr_i;
  logic [2:0]        arprot_i;
  logic              rvalid_o, rready_i;
  logic [DATA_W-1:0] rdata_o;
  logic [1:0]        rresp_o;
  logic              wr_valid_o;
  logic [IDX_W-1:0]  wr_sel_o;
  logic [DATA_W-1:0] wr_data_o;
  logic [3:0]        wr_be_o;
  logic              wr_ready_i;
  logic              rd_req_o;
  logic [IDX_W-1:0]  rd_sel_o;
  logic              rd_ack_i;
  logic [DATA_W-1:0] rd_data_i;

  int nchk = 0;
  int nerr = 0;

  always #5 clk_i = ~clk_i;

  axil_crypto_slave #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ADDR_LSB(0), .IDX_W(IDX_W), .ACK_TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i), .awprot_i(awprot_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .be_i(be_i),
    .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o),
    .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i), .arprot_i(arprot_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o),
    .wr_valid_o(wr_valid_o), .wr_sel_o(wr_sel_o), .wr_data_o(wr_data_o), .wr_be_o(wr_be_o),
    .wr_ready_i(wr_ready_i),
    .rd_req_o(rd_req_o), .rd_sel_o(rd_sel_o), .rd_ack_i(rd_ack_i), .rd_data_i(rd_data_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    nchk++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference access rules: writable NONCE/AD/PT/KEY, readable CT/STATUS.
  function automatic bit m_wr_ok(input int idx, input bit priv);
    bit ok;
    bit prot_chk;
    prot_chk = 1'b0;
`ifdef AXIL_PROT_CHECK_EN
    prot_chk = 1'b1;
`endif
    ok = (idx == 0) || (idx == 1) || (idx == 2) || (idx == 5);
    if (prot_chk && idx == 5 && !priv) ok = 1'b0;
    return ok;
  endfunction

  function automatic bit m_rd_ok(input int idx);
    return (idx == 3) || (idx == 4);
  endfunction

  task automatic rnd_write(input int idx, input logic [31:0] data, input logic [3:0] be,
                           input logic [2:0] prot, input int dly, input int aw_t,
                           input int w_t, input int b_dly);
    bit aw_pend = 1'b1, w_pend = 1'b1, done = 1'b0, ok, good;
    int wv_cnt = 0, acc = 0, bwait = 0;
    logic [1:0] resp = 2'b11;
    logic [IDX_W-1:0] sel_seen = '0;
    logic [31:0] data_seen = '0;
    logic [3:0] be_seen = '0;
    ok   = m_wr_ok(idx, prot[0]);
    good = ok && (dly < TO);
    awaddr_i = 32'h0010_0000 | 32'(idx);
    awprot_i = prot;
    wdata_i  = data;
    be_i     = be;
    for (int c = 0; c < 80 && !done; c++) begin
      bit aw_f, w_f;
      awvalid_i = aw_pend && (c >= aw_t);
      wvalid_i  = w_pend && (c >= w_t);
      aw_f = awvalid_i && awready_o;
      w_f  = wvalid_i && wready_o;
      wr_ready_i = 1'b0;
      if (wr_valid_o) begin
        if (wv_cnt == dly) begin
          wr_ready_i = 1'b1;
          acc++;
          sel_seen  = wr_sel_o;
          data_seen = wr_data_o;
          be_seen   = wr_be_o;
        end
        wv_cnt++;
      end
      bready_i = 1'b0;
      if (bvalid_o) begin
        if (bwait == b_dly) begin
          bready_i = 1'b1;
          resp = bresp_o;
          done = 1'b1;
        end
        bwait++;
      end
      tick();
      if (aw_f) aw_pend = 1'b0;
      if (w_f) w_pend = 1'b0;
    end
    awvalid_i = 0; wvalid_i = 0; wr_ready_i = 0; bready_i = 0;
    check("rw_done", 64'(done), 64'd1);
    check("rw_resp", 64'(resp), good ? 64'd0 : 64'd2);
    check("rw_beats", 64'(wv_cnt), ok ? ((dly < TO) ? 64'(dly + 1) : 64'(TO)) : 64'd0);
    check("rw_acc", 64'(acc), 64'(good));
    if (good) check("rw_core", 64'({sel_seen, data_seen, be_seen}), 64'({3'(idx), data, be}));
  endtask

  task automatic rnd_read(input int idx, input logic [31:0] data, input int dly, input int r_dly);
    bit ar_pend = 1'b1, done = 1'b0, ok, good, unstable = 1'b0;
    int rq_cnt = 0, rwait = 0;
    logic [1:0] resp = 2'b11;
    logic [IDX_W-1:0] sel_seen = '0;
    logic [31:0] first = '0, seen = '1;
    ok   = m_rd_ok(idx);
    good = ok && (dly < TO);
    araddr_i = 32'h0010_0000 | 32'(idx);
    arprot_i = 3'($urandom);
    for (int c = 0; c < 80 && !done; c++) begin
      bit ar_f;
      arvalid_i = ar_pend;
      ar_f = arvalid_i && arready_o;
      rd_ack_i  = 1'b0;
      rd_data_i = $urandom;
      if (rd_req_o) begin
        if (rq_cnt == dly) begin
          rd_ack_i  = 1'b1;
          rd_data_i = data;
          sel_seen  = rd_sel_o;
        end
        rq_cnt++;
      end
      rready_i = 1'b0;
      if (rvalid_o) begin
        if (rwait == 0) first = rdata_o;
        else if (rdata_o !== first) unstable = 1'b1;
        if (rwait == r_dly) begin
          rready_i = 1'b1;
          seen = rdata_o;
          resp = rresp_o;
          done = 1'b1;
        end
        rwait++;
      end
      tick();
      if (ar_f) ar_pend = 1'b0;
    end
    arvalid_i = 0; rd_ack_i = 0; rready_i = 0;
    check("rr_done", 64'(done), 64'd1);
    check("rr_resp", 64'(resp), good ? 64'd0 : 64'd2);
    check("rr_data", 64'(seen), good ? 64'(data) : 64'd0);
    check("rr_beats", 64'(rq_cnt), ok ? ((dly < TO) ? 64'(dly + 1) : 64'(TO)) : 64'd0);
    check("rr_stable", 64'(unstable), 64'd0);
    if (good) check("rr_sel", 64'(sel_seen), 64'(idx));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit seen_b;
    rst_i = 1; awvalid_i = 0; awaddr_i = 0; awprot_i = 0; wvalid_i = 0; wdata_i = 0; be_i = 0;
    bready_i = 0; arvalid_i = 0; araddr_i = 0; arprot_i = 0; rready_i = 0;
    wr_ready_i = 0; rd_ack_i = 0; rd_data_i = 0;
    repeat (3) tick();
    check("rst_ctrl", 64'({awready_o, wready_o, bvalid_o, bresp_o, arready_o, rvalid_o,
                          rresp_o, wr_valid_o, rd_req_o}), 64'd0);
    check("rst_data", {rdata_o, wr_data_o}, 64'd0);
    check("rst_sel", 64'({wr_sel_o, rd_sel_o, wr_be_o}), 64'd0);
    rst_i = 0;
    check("rdy_pre", 64'({awready_o, wready_o, arready_o}), 64'd0);
    tick();
    check("rdy_post", 64'({awready_o, wready_o, arready_o}), 64'b111);

    // KEY write, AW and W together, core ready
    awvalid_i = 1; awaddr_i = 32'h0010_0005; awprot_i = 3'b001;
    wvalid_i = 1; wdata_i = 32'h9D79_B1A3; be_i = 4'hF; wr_ready_i = 1;
    tick();
    awvalid_i = 0; wvalid_i = 0;
    check("key_core", 64'({wr_valid_o, wr_sel_o, wr_data_o, bvalid_o}),
          64'({1'b1, 3'd5, 32'h9D79_B1A3, 1'b0}));
    tick();
    wr_ready_i = 0;
    check("key_b", 64'({bvalid_o, bresp_o, wr_valid_o}), 64'({1'b1, 2'b00, 1'b0}));
    // new AW during the B handshake must wait one cycle
    bready_i = 1; awvalid_i = 1; awaddr_i = 32'h0010_0001;
    check("aw_during_b", 64'(awready_o), 64'd0);
    tick();
    bready_i = 0;
    check("b_done", 64'({bvalid_o, awready_o}), 64'b01);
    tick();
    awvalid_i = 0;
    check("aw_after_b", 64'({awready_o, wready_o}), 64'b01);
    wvalid_i = 1; wdata_i = 32'h0BAD_F00D; wr_ready_i = 1;
    tick();
    wvalid_i = 0;
    check("ad_core", 64'({wr_valid_o, wr_sel_o, wr_data_o}), 64'({1'b1, 3'd1, 32'h0BAD_F00D}));
    tick();
    wr_ready_i = 0; bready_i = 1;
    tick();
    bready_i = 0;

    // W three cycles ahead of AW, core stalls five cycles
    wvalid_i = 1; wdata_i = 32'h1AB3_C589; be_i = 4'h3;
    tick();
    wvalid_i = 0;
    check("w_first", 64'({wready_o, awready_o, wr_valid_o}), 64'b010);
    tick();
    tick();
    awvalid_i = 1; awaddr_i = 32'h0010_0001;
    tick();
    awvalid_i = 0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (wr_valid_o === 1'b1 && wr_sel_o === 3'd1 && wr_data_o === 32'h1AB3_C589 &&
          wr_be_o === 4'h3 && awready_o === 1'b0) cnt++;
      tick();
    end
    check("stall_stable", 64'(cnt), 64'd5);
    wr_ready_i = 1;
    tick();
    wr_ready_i = 0;
    check("stall_b", 64'({bvalid_o, bresp_o, awready_o}), 64'({1'b1, 2'b00, 1'b0}));
    tick();
    check("b_hold", 64'({bvalid_o, awready_o}), 64'b10);
    bready_i = 1;
    tick();
    bready_i = 0;
    check("stall_done", 64'(bvalid_o), 64'd0);

    // illegal write to CT and illegal read of index 6
    awvalid_i = 1; awaddr_i = 32'h0010_0003; wvalid_i = 1; wr_ready_i = 1;
    tick();
    awvalid_i = 0; wvalid_i = 0;
    check("ill_wr", 64'({wr_valid_o, bvalid_o, bresp_o}), 64'({1'b0, 1'b1, 2'b10}));
    wr_ready_i = 0; bready_i = 1;
    tick();
    bready_i = 0;
    arvalid_i = 1; araddr_i = 32'h0010_0006; rd_data_i = 32'hFFFF_FFFF;
    tick();
    arvalid_i = 0;
    check("ill_rd", 64'({rd_req_o, rvalid_o, rresp_o, rdata_o}), 64'({1'b0, 1'b1, 2'b10, 32'd0}));
    rready_i = 1;
    tick();
    rready_i = 0;

    // CT read with slow core and slow master; early rready has no effect
    rready_i = 1;
    tick();
    check("rready_early", 64'(rvalid_o), 64'd0);
    rready_i = 0;
    arvalid_i = 1; araddr_i = 32'h0010_0003;
    tick();
    arvalid_i = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (rd_req_o === 1'b1 && rd_sel_o === 3'd3 && rvalid_o === 1'b0) cnt++;
      tick();
    end
    check("ct_req", 64'(cnt), 64'd4);
    rd_ack_i = 1; rd_data_i = 32'h6AAC_9780;
    tick();
    rd_ack_i = 0; rd_data_i = 32'h1234_5678;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (rvalid_o === 1'b1 && rdata_o === 32'h6AAC_9780 && rresp_o === 2'b00 && rd_req_o === 1'b0) cnt++;
      tick();
    end
    check("ct_hold", 64'(cnt), 64'd3);
    rready_i = 1;
    tick();
    rready_i = 0;
    check("ct_done", 64'({rvalid_o, arready_o}), 64'b01);

    // write timeout, then late ack
    awvalid_i = 1; awaddr_i = 32'h0010_0002; wvalid_i = 1; wdata_i = 32'hCAFE_0001;
    tick();
    awvalid_i = 0; wvalid_i = 0;
    cnt = 0;
    for (int i = 0; i < 20 && wr_valid_o; i++) begin
      cnt++;
      tick();
    end
    check("to_beats", 64'(cnt), 64'(TO));
    check("to_b", 64'({bvalid_o, bresp_o}), 64'({1'b1, 2'b10}));
    wr_ready_i = 1;
    tick();
    bready_i = 1;
    tick();
    bready_i = 0;
    seen_b = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_b |= (bvalid_o !== 1'b0) || (wr_valid_o !== 1'b0);
    end
    wr_ready_i = 0;
    check("late_ack", 64'(seen_b), 64'd0);

    // read timeout, late ack ignored
    arvalid_i = 1; araddr_i = 32'h0010_0004;
    tick();
    arvalid_i = 0;
    cnt = 0;
    for (int i = 0; i < 20 && rd_req_o; i++) begin
      cnt++;
      tick();
    end
    check("rto_beats", 64'(cnt), 64'(TO));
    rd_ack_i = 1; rd_data_i = 32'hDEAD_BEEF;
    tick();
    rd_ack_i = 0;
    check("rto_r", 64'({rvalid_o, rresp_o, rdata_o}), 64'({1'b1, 2'b10, 32'd0}));
    rready_i = 1;
    tick();
    rready_i = 0;

    // concurrent PT write and STATUS read
    awvalid_i = 1; awaddr_i = 32'h0010_0002; wvalid_i = 1; wdata_i = 32'h5555_AAAA;
    arvalid_i = 1; araddr_i = 32'h0010_0004;
    tick();
    awvalid_i = 0; wvalid_i = 0; arvalid_i = 0;
    check("cc_both", 64'({wr_valid_o, rd_req_o, wr_sel_o, rd_sel_o}), 64'({2'b11, 3'd2, 3'd4}));
    wr_ready_i = 1;
    tick();
    wr_ready_i = 0;
    check("cc_w", 64'({bvalid_o, rd_req_o, rvalid_o}), 64'b110);
    rd_ack_i = 1; rd_data_i = 32'h0000_00A5;
    tick();
    rd_ack_i = 0;
    check("cc_r", 64'({bvalid_o, rvalid_o, rdata_o}), 64'({2'b11, 32'h0000_00A5}));
    bready_i = 1; rready_i = 1;
    tick();
    bready_i = 0; rready_i = 0;
    check("cc_done", 64'({bvalid_o, rvalid_o}), 64'd0);

    // reset while the core write is pending
    awvalid_i = 1; awaddr_i = 32'h0010_0000; wvalid_i = 1; wdata_i = 32'h7777_1111;
    tick();
    awvalid_i = 0; wvalid_i = 0;
    check("pre_rst", 64'(wr_valid_o), 64'd1);
    #2 rst_i = 1;
    #1;
    check("mid_rst_ctrl", 64'({awready_o, wready_o, bvalid_o, bresp_o, arready_o, rvalid_o,
                               rresp_o, wr_valid_o, rd_req_o}), 64'd0);
    check("mid_rst_data", {rdata_o, wr_data_o}, 64'd0);
    tick();
    tick();
    rst_i = 0; wr_ready_i = 1;
    seen_b = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen_b |= (bvalid_o !== 1'b0) || (wr_valid_o !== 1'b0);
    end
    wr_ready_i = 0;
    check("post_rst_quiet", 64'(seen_b), 64'd0);
    check("post_rst_rdy", 64'({awready_o, wready_o, arready_o}), 64'b111);

    // randomized transactions against the reference rules
    for (int n = 0; n < 30; n++) begin
      rnd_write($urandom_range(0, 7), $urandom, 4'($urandom), 3'($urandom),
                $urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2));
      rnd_read($urandom_range(0, 7), $urandom, $urandom_range(0, 10), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/axil_crypto_slave.md
Name: axil_crypto_slave

Overview:
- AXI4-Lite responder front-end for the crypto cores; sits between the bus_axi device port and a core such as the Ascon engine.
- Turns bus write/read transactions into a simple word-wide register-channel interface: key, nonce, AD, plaintext in; ciphertext/tag and status out.
- Applies core back-pressure by holding off AW/W/AR acceptance.
- Returns proper B/R responses, including SLVERR for unmapped indices and core timeouts.

Parameters:
- DATA_W, 32, bus and core data width.
- ADDR_W, 32, AXI address width.
- ADDR_LSB, 0, LSB of the register index within the address (0 = word-indexed map, 2 = byte-addressed map).
- IDX_W, 3, register index width.
- ACK_TIMEOUT, 256, cycles to wait for a core ack before answering SLVERR; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- awvalid_i  in  1  write address valid
- awready_o  out  1  write address ready
- awaddr_i  in  ADDR_W  write address
- awprot_i  in  3  write protection
- wvalid_i  in  1  write data valid
- wready_o  out  1  write data ready
- wdata_i  in  DATA_W  write data
- be_i  in  DATA_W/8  write strobes
- bvalid_o  out  1  write response valid
- bready_i  in  1  write response ready
- bresp_o  out  2  write response
- arvalid_i  in  1  read address valid
- arready_o  out  1  read address ready
- araddr_i  in  ADDR_W  read address
- arprot_i  in  3  read protection
- rvalid_o  out  1  read data valid
- rready_i  in  1  read data ready
- rdata_o  out  DATA_W  read data
- rresp_o  out  2  read response
- wr_valid_o  out  1  core write request
- wr_sel_o  out  IDX_W  core register index
- wr_data_o  out  DATA_W  core write data
- wr_be_o  out  DATA_W/8  core strobes
- wr_ready_i  in  1  core accepts write
- rd_req_o  out  1  core read request
- rd_sel_o  out  IDX_W  core read index
- rd_ack_i  in  1  core read data valid
- rd_data_i  in  DATA_W  core read data

Behaviour:
- Interface facts: one clock, clk_i. rst_i is asynchronous, active-high.
- Reset values: all outputs are 0.
  - awready_o, wready_o and arready_o are registered and rise on the first clk_i edge after rst_i deasserts.
- Register map (index = addr[ADDR_LSB +: IDX_W]):
  - 0 NONCE (W)
  - 1 AD (W)
  - 2 PT (W)
  - 3 CT (R)
  - 4 STATUS (R)
  - 5 KEY (W)
  - 6, 7 unmapped
  - Writes to 3/4, reads of 0/1/2/5, and any access to 6/7 are illegal: SLVERR, no core transaction, rdata_o = 0.
- Write FSM: W_IDLE -> W_ADDR_WAIT / W_DATA_WAIT -> W_CORE -> W_RESP -> W_IDLE.
  - W_IDLE: awready_o = wready_o = 1. AW and W are accepted independently, in the same or different cycles.
  - Once a channel has been captured, its ready drops until W_IDLE is re-entered.
  - When both are captured: legal index goes to W_CORE; illegal index goes to W_RESP with SLVERR.
  - W_CORE: wr_valid_o = 1 with stable sel/data/be until the cycle wr_ready_i = 1, then W_RESP with OKAY.
  - W_RESP: bvalid_o = 1 with stable bresp_o until bready_i = 1, then W_IDLE.
  - Minimum latency, with AW and W in the same cycle and wr_ready_i already high: bvalid_o rises 2 cycles after acceptance.
- Read FSM: R_IDLE (arready_o = 1) -> R_CORE -> R_RESP -> R_IDLE.
  - R_CORE: rd_req_o held until rd_ack_i, at which point rd_data_i is latched.
  - R_RESP: rvalid_o held with stable rdata_o/rresp_o until rready_i.
- Read and write FSMs are fully independent. wr_valid_o and rd_req_o may be asserted in the same cycle.
- Timeout (ACK_TIMEOUT > 0):
  - A counter clears on entry to W_CORE or R_CORE.
  - On reaching ACK_TIMEOUT with no ack: drop the core request, respond SLVERR (read data 0).
  - A late ack arriving after the timeout is ignored.
- Simultaneous events:
  - bready_i/rready_i asserted before the valid is present has no effect.
  - A new AW presented in the same cycle that the B handshake completes is not accepted; it is accepted the cycle after.
- Reset mid-operation: any pending transaction is discarded and no response is issued.

Optional Feature:
- Macro: AXIL_PROT_CHECK_EN.
- Defined: writes to KEY (index 5) with awprot_i[0] = 0 (unprivileged) complete with SLVERR and no core write. Reads of STATUS are unaffected.
- Undefined: awprot_i/arprot_i are ignored.

Decomposition:
- Package axil_slave_pkg:
  - resp constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - register index constants IDX_NONCE/AD/PT/CT/STATUS/KEY
  - write and read state enums
  - legality functions wr_legal(idx) and rd_legal(idx)
- One sub-module, axil_wr_chan: the write FSM including its timeout counter. The read FSM stays in the top.

Test Plan:
- Word-indexed KEY write: awaddr = 0x100005, wdata = 0x9D79B1A3 (AW and W same cycle), wr_ready_i = 1 -> wr_sel_o = 5, wr_data_o = 0x9D79B1A3 for 1 cycle; bvalid_o 2 cycles after acceptance, bresp = 00.
- W before AW: wdata = 0x1AB3C589 three cycles ahead of awaddr = 0x100001; wr_ready_i low for 5 cycles -> wr_valid_o held stable 5 cycles; awready_o low until B completes; bresp = 00.
- Illegal write: awaddr = 0x100003 -> no wr_valid_o, bresp = 10. Illegal read: araddr = 0x100006 -> rdata = 0, rresp = 10.
- CT read: araddr = 0x100003, rd_ack_i after 4 cycles with 0x6AAC9780, rready_i delayed 3 cycles -> rvalid_o held, rdata_o = 0x6AAC9780, rresp = 00.
- Timeout: ACK_TIMEOUT = 8, wr_ready_i stuck low -> bresp = 10 after 8 cycles in W_CORE; a late wr_ready_i causes no second response.
- Concurrency and reset: PT write and STATUS read issued together -> both complete independently. Then assert rst_i during W_CORE -> all outputs 0 immediately and no bvalid_o after release.
